// File: rtl/alu_control_seq.sv
// LEGv8 ALU control: decodes {ALUOp, opcode} into a registered 4-bit ALU operation and
// sequences multi-cycle MUL/UDIV results behind a valid/ready handshake.
module alu_control_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_operation,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int LAT_W = 6;
  localparam int N_OPS = 9;

  localparam logic [10:0] OPC_TAB [N_OPS] = '{
    11'b10001010000, 11'b10101010000, 11'b10001011000,
    11'b11001010000, 11'b11010011011, 11'b11010011010,
    11'b11001011000, 11'b10011011000, 11'b10011010110
  };
  localparam logic [3:0] CODE_TAB [N_OPS] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9
  };

  localparam logic [LAT_W-1:0] MUL_M1 = LAT_W'(MUL_LAT - 1);
  localparam logic [LAT_W-1:0] DIV_M1 = LAT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, VALID} state_t;

  state_t           state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       op_reg, op_next;
  logic             ill_reg, ill_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [N_OPS-1:0] hit;
  logic [3:0]       dec_op;
  logic             dec_ill;
  logic [LAT_W-1:0] dec_lat_m1;

  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_match
      assign hit[gi] = (opcode == OPC_TAB[gi]);
    end
  endgenerate

  always_comb begin
    dec_op  = 4'hF;
    dec_ill = 1'b1;
    case (alu_op)
      2'b00: begin dec_op = 4'd2; dec_ill = 1'b0; end
      2'b01: begin dec_op = 4'd7; dec_ill = 1'b0; end
      2'b10: begin
        for (int i = 0; i < N_OPS; i++) begin
          if (hit[i]) begin
            dec_op  = CODE_TAB[i];
            dec_ill = 1'b0;
          end
        end
      end
      default: begin dec_op = 4'hF; dec_ill = 1'b1; end
    endcase
  end

  // Remaining cycles after accept; zero means the result is presented next cycle.
  always_comb begin
    dec_lat_m1 = '0;
    if (dec_op == 4'd8)      dec_lat_m1 = MUL_M1;
    else if (dec_op == 4'd9) dec_lat_m1 = DIV_M1;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    ill_next   = ill_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        busy = 1'b1;
        if (cnt_reg == LAT_W'(1)) begin
          state_next = VALID;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      VALID: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A new accept overrides the hold/idle decision, giving back-to-back results.
    if (in_valid && in_ready) begin
      op_next  = dec_op;
      ill_next = dec_ill;
      if (dec_lat_m1 == '0) begin
        state_next = VALID;
      end else begin
        state_next = BUSY;
        cnt_next   = dec_lat_m1;
      end
    end
    count_next = (out_valid && out_ready) ? count_reg + CNT_W'(1) : count_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      ill_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      ill_reg   <= ill_next;
      count_reg <= count_next;
    end
  end

  assign alu_operation = op_reg;
  assign illegal       = ill_reg;
  assign op_count      = count_reg;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized and directed bench for alu_control_seq: accepted requests are queued with their
// expected result and timing; a monitor compares DUT outputs every cycle.
module tb_alu_control_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
  localparam int CNT_W   = 2;

  localparam logic [10:0] O_AND  = 11'b10001010000;
  localparam logic [10:0] O_ORR  = 11'b10101010000;
  localparam logic [10:0] O_ADD  = 11'b10001011000;
  localparam logic [10:0] O_EOR  = 11'b11001010000;
  localparam logic [10:0] O_LSL  = 11'b11010011011;
  localparam logic [10:0] O_LSR  = 11'b11010011010;
  localparam logic [10:0] O_SUB  = 11'b11001011000;
  localparam logic [10:0] O_MUL  = 11'b10011011000;
  localparam logic [10:0] O_UDIV = 11'b10011010110;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [10:0]      opcode;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_operation;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  alu_control_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .alu_operation(alu_operation), .illegal(illegal), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic       ill;
    int         lat;
    int         t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   cnt_exp = 0;
  int   last_op = 0;
  int   last_ill = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] a, input logic [10:0] o, input int t);
    exp_t e;
    e.t = t;
    e.ill = 1'b0;
    case (a)
      2'b00: e.op = 4'd2;
      2'b01: e.op = 4'd7;
      2'b10: begin
        case (o)
          O_AND:  e.op = 4'd0;
          O_ORR:  e.op = 4'd1;
          O_ADD:  e.op = 4'd2;
          O_EOR:  e.op = 4'd3;
          O_LSL:  e.op = 4'd4;
          O_LSR:  e.op = 4'd5;
          O_SUB:  e.op = 4'd6;
          O_MUL:  e.op = 4'd8;
          O_UDIV: e.op = 4'd9;
          default: begin e.op = 4'hF; e.ill = 1'b1; end
        endcase
      end
      default: begin e.op = 4'hF; e.ill = 1'b1; end
    endcase
    e.lat = (e.op == 4'd8) ? MUL_LAT : (e.op == 4'd9) ? DIV_LAT : 1;
    return e;
  endfunction

  function automatic logic [10:0] pick_opc(input int i);
    case (i)
      0: return O_AND;  1: return O_ORR;  2: return O_ADD;
      3: return O_EOR;  4: return O_LSL;  5: return O_LSR;
      6: return O_SUB;  7: return O_MUL;  8: return O_UDIV;
      default: return 11'($urandom);
    endcase
  endfunction

  // Monitor: head of queue becomes active the cycle after its accept and valid lat cycles after.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      bit active, vexp, bexp, rexp;
      active = (q.size() > 0) && (cyc > q[0].t);
      vexp   = active && (cyc >= q[0].t + q[0].lat);
      bexp   = active && !vexp;
      rexp   = !active || (vexp && out_ready);
      chk("out_valid", out_valid, vexp);
      chk("busy", busy, bexp);
      chk("in_ready", in_ready, rexp);
      chk("op_count", op_count, cnt_exp);
      if (active) begin
        chk("alu_operation", alu_operation, q[0].op);
        chk("illegal", illegal, q[0].ill);
      end else begin
        chk("alu_operation_hold", alu_operation, last_op);
        chk("illegal_hold", illegal, last_ill);
      end
      if (vexp && out_ready) begin
        last_op  = q[0].op;
        last_ill = q[0].ill;
        void'(q.pop_front());
        cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
        $display("[TB] cycle %0d result op=%0d illegal=%0d op_count_next=%0d",
                 cyc, last_op, last_ill, cnt_exp);
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive(input bit v, input logic [1:0] a, input logic [10:0] o, input bit r,
                       output bit acc);
    in_valid  = v;
    alu_op    = a;
    opcode    = o;
    out_ready = r;
    @(negedge clk);
    #1;
    acc = v && in_ready;
    if (acc) q.push_back(model(a, o, cyc));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] a, input logic [10:0] o);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 60) begin
      drive(1'b1, a, o, 1'b1, acc);
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout cycle=%0d got=no_accept expected=accept", cyc);
    end
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 11'd0, r, acc);
  endtask

  initial begin
    bit acc;
    bit pend;
    logic [1:0]  ca;
    logic [10:0] co;
    reset_n = 1'b0;
    in_valid = 1'b0;
    alu_op = 2'b00;
    opcode = 11'd0;
    out_ready = 1'b0;
    #22;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_operation", alu_operation, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    issue(2'b10, O_ADD); issue(2'b10, O_SUB); issue(2'b10, O_AND); issue(2'b10, O_ORR);
    idle(3, 1'b1);

    issue(2'b10, O_MUL);  idle(6, 1'b1);
    issue(2'b10, O_UDIV); idle(10, 1'b1);

    issue(2'b10, O_ADD);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b10, O_LSL, 1'b0, acc);
    issue(2'b10, O_LSL);
    idle(3, 1'b1);

    issue(2'b10, 11'h7FF);
    issue(2'b11, 11'($urandom));
    issue(2'b00, 11'($urandom));
    issue(2'b01, 11'($urandom));
    issue(2'b10, O_ADD);
    idle(3, 1'b1);

    for (int i = 0; i < 5; i++) issue(2'b10, O_EOR);
    idle(2, 1'b1);

    // Reset while a MUL is mid-flight with two cycles to go.
    if (cnt_exp == 0) begin
      issue(2'b10, O_ADD);
      idle(2, 1'b1);
    end
    issue(2'b10, O_MUL);
    idle(1, 1'b1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_alu_operation", alu_operation, 0);
    q.delete();
    cnt_exp = 0;
    last_op = 0;
    last_ill = 0;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_busy", busy, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    pend = 1'b0;
    ca = 2'b00;
    co = 11'd0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: ca = 2'b00;
          1: ca = 2'b01;
          2: ca = 2'b11;
          default: ca = 2'b10;
        endcase
        co = pick_opc($urandom_range(0, 10));
      end
      drive(pend, ca, co, ($urandom_range(0, 3) != 0), acc);
      if (acc) pend = 1'b0;
    end
    idle(40, 1'b1);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
